imem_sync: RTL and testbench

- Parametrised, synchronous-read instruction memory; successor to the combinational word-indexed instruction store.
- Feeds the IF/ID stage with a registered instruction plus valid and fault flags, and honours pipeline stall and flush.
- Adds a byte-serial load port so the debug/UART loader can program the program image at run time.
- Fetch and load are mutually exclusive, selected by an internal two-state FSM.

---
 rtl/imem_sync.sv | 136 +++++++++++++
 tb/tb_imem_sync.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_sync.sv
// imem_sync: synchronous-read instruction memory with a registered IF/ID
// output and a byte-serial program loader selected by a RUN/LOAD FSM.
module imem_sync #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH+1:0] fetch_addr,
  input  logic                  stall,
  input  logic                  flush,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic                  fault_misalign,
  output logic                  fault_range,
  input  logic                  load_en,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_done,
  output logic                  load_overflow,
  output logic                  busy
);

  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {RUN, LOAD} state_t;

  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH:0]   ptr;
  logic [1:0]            lane;
  logic [23:0]           asm_q;

  logic [ADDR_WIDTH-1:0] idx;
  logic [MW-1:0]         ridx;
  logic [MW-1:0]         widx;
  logic                  mis;
  logic                  rng;
  logic                  room;
  logic                  full_wr;
  logic                  part_wr;
  logic                  we;
  logic [31:0]           wdata;

  assign idx  = fetch_addr[ADDR_WIDTH+1:2];
  assign ridx = idx[MW-1:0];
  assign widx = ptr[MW-1:0];
  assign mis  = fetch_addr[1:0] != 2'b00;
  assign rng  = {1'b0, idx} >= DEPTH_W;
  assign room = ptr < DEPTH_W;
  assign busy = state == LOAD;

  assign full_wr = busy && load_en && load_valid
                && room && lane == 2'd3;
  // Unfilled upper bytes of asm_q are zero, giving the padding.
  assign part_wr = busy && !load_en && lane != 2'd0 && room;
  assign we      = !rst && (full_wr || part_wr);
  assign wdata   = full_wr ? {load_byte, asm_q}
                           : {8'h00, asm_q};

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      instr          <= NOP_WORD;
      instr_valid    <= 1'b0;
      fault_misalign <= 1'b0;
      fault_range    <= 1'b0;
      load_done      <= 1'b0;
      load_overflow  <= 1'b0;
      ptr            <= '0;
      lane           <= 2'd0;
      asm_q          <= 24'h0;
    end else begin
      load_done <= 1'b0;
      unique case (state)
        RUN: begin
          if (load_en) begin
            state         <= LOAD;
            ptr           <= '0;
            lane          <= 2'd0;
            asm_q         <= 24'h0;
            load_overflow <= 1'b0;
            instr_valid   <= 1'b0;
          end else if (flush) begin
            instr_valid    <= 1'b0;
            instr          <= NOP_WORD;
            fault_misalign <= 1'b0;
            fault_range    <= 1'b0;
          end else if (stall) begin
            instr_valid <= instr_valid;
          end else if (fetch_req) begin
            instr_valid    <= 1'b1;
            fault_misalign <= mis;
            fault_range    <= rng;
            instr          <= (mis || rng) ? NOP_WORD
                                           : mem[ridx];
          end else begin
            instr_valid <= 1'b0;
          end
        end
        LOAD: begin
          if (!load_en) begin
            state     <= RUN;
            load_done <= 1'b1;
            lane      <= 2'd0;
            asm_q     <= 24'h0;
          end else if (load_valid) begin
            if (!room) begin
              load_overflow <= 1'b1;
            end else if (lane == 2'd3) begin
              ptr   <= ptr + 1'b1;
              lane  <= 2'd0;
              asm_q <= 24'h0;
            end else begin
              lane <= lane + 2'd1;
              unique case (lane)
                2'd0:    asm_q[7:0]   <= load_byte;
                2'd1:    asm_q[15:8]  <= load_byte;
                default: asm_q[23:16] <= load_byte;
              endcase
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: directed bench for imem_sync using two instances,
// a 512-word store and a 2-word store for the overflow path.
module tb_imem_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [11:0] fetch_addr;
  logic        stall;
  logic        flush;
  logic        load_en;
  logic        load_valid;
  logic [7:0]  load_byte;

  logic [31:0] a_instr, b_instr;
  logic        a_valid, b_valid;
  logic        a_mis, b_mis;
  logic        a_rng, b_rng;
  logic        a_done, b_done;
  logic        a_ovf, b_ovf;
  logic        a_busy, b_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imem_sync #(.ADDR_WIDTH(10), .DEPTH(512)) u_a (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .stall(stall), .flush(flush),
    .instr(a_instr), .instr_valid(a_valid),
    .fault_misalign(a_mis), .fault_range(a_rng),
    .load_en(load_en), .load_valid(load_valid),
    .load_byte(load_byte), .load_done(a_done),
    .load_overflow(a_ovf), .busy(a_busy)
  );

  imem_sync #(.ADDR_WIDTH(10), .DEPTH(2)) u_b (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .stall(stall), .flush(flush),
    .instr(b_instr), .instr_valid(b_valid),
    .fault_misalign(b_mis), .fault_range(b_rng),
    .load_en(load_en), .load_valid(load_valid),
    .load_byte(load_byte), .load_done(b_done),
    .load_overflow(b_ovf), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    load_valid = 1'b1;
    load_byte  = b;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic fetch(input logic [11:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    stall = 1'b0; flush = 1'b0; load_en = 1'b0;
    load_valid = 1'b0; load_byte = 8'h00;
    tick(); tick();
    chk("rst_instr", a_instr, 32'h0);
    chk("rst_valid", a_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_ovf", b_ovf, 0);
    chk("rst_faults", {a_mis, a_rng}, 0);
    rst = 1'b0;
    tick();

    // load two words then return to RUN
    load_en = 1'b1;
    tick();
    chk("load_busy", a_busy, 1);
    send(8'h13); send(8'h00); send(8'h00); send(8'h20);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("load_busy_hold", a_busy, 1);
    chk("load_no_done", a_done, 0);
    load_en = 1'b0;
    tick();
    chk("done_pulse", a_done, 1);
    chk("done_busy", a_busy, 0);
    tick();
    chk("done_clear", a_done, 0);

    fetch(12'h000);
    chk("f0_instr", a_instr, 32'h2000_0013);
    chk("f0_valid", a_valid, 1);
    fetch(12'h004);
    chk("f1_instr", a_instr, 32'hDEAD_BEEF);
    chk("f1_valid", a_valid, 1);
    fetch_req = 1'b0;
    tick();
    chk("idle_valid", a_valid, 0);
    chk("idle_hold", a_instr, 32'hDEAD_BEEF);

    // stall holds, flush kills even under stall
    fetch(12'h004);
    chk("s_instr", a_instr, 32'hDEAD_BEEF);
    fetch_addr = 12'h000;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", a_instr, 32'hDEAD_BEEF);
      chk("stall_valid", a_valid, 1);
    end
    flush = 1'b1;
    tick();
    chk("flush_valid", a_valid, 0);
    chk("flush_instr", a_instr, 32'h0);
    flush = 1'b0; stall = 1'b0;

    // faults
    fetch(12'h006);
    chk("mis_flag", a_mis, 1);
    chk("mis_rng", a_rng, 0);
    chk("mis_instr", a_instr, 32'h0);
    chk("mis_valid", a_valid, 1);
    fetch(12'h800);
    chk("rng_flag", a_rng, 1);
    chk("rng_mis", a_mis, 0);
    chk("rng_instr", a_instr, 32'h0);
    fetch(12'h008);
    chk("rng_b_flag", b_rng, 1);
    fetch_req = 1'b0;
    tick();

    // nine bytes into a 2-word store
    load_en = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) send(8'(i));
    chk("ovf_b", b_ovf, 1);
    chk("ovf_a", a_ovf, 0);
    load_en = 1'b0;
    tick();
    chk("ovf_done", b_done, 1);
    tick();
    chk("ovf_sticky", b_ovf, 1);
    fetch(12'h000);
    chk("ovf_w0", b_instr, 32'h0403_0201);
    fetch(12'h004);
    chk("ovf_w1", b_instr, 32'h0807_0605);
    fetch_req = 1'b0;
    tick();

    // partial word
    load_en = 1'b1;
    tick();
    chk("ovf_cleared", b_ovf, 0);
    send(8'hAA); send(8'hBB);
    load_en = 1'b0;
    tick();
    chk("part_done", a_done, 1);
    tick();
    fetch(12'h000);
    chk("part_word", a_instr, 32'h0000_BBAA);
    fetch_req = 1'b0;
    tick();

    // reset in the middle of a word
    load_en = 1'b1;
    tick();
    send(8'h11); send(8'h22);
    rst = 1'b1;
    load_en = 1'b0;
    tick();
    chk("mrst_busy", a_busy, 0);
    chk("mrst_valid", a_valid, 0);
    chk("mrst_done", a_done, 0);
    rst = 1'b0;
    tick();
    chk("mrst_no_done", a_done, 0);
    fetch(12'h000);
    chk("mrst_keep", a_instr, 32'h0000_BBAA);
    fetch_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
